// File: rtl/i2s_clkctrl.sv
// I2S clock-generator sequencer: applies config/stop only at frame boundaries plus a fixed gap.
// Optional drain watchdog enabled by defining I2S_CLKCTRL_TMO_EN.
module i2s_clkctrl #(
    parameter int unsigned DIV_WIDTH     = 8,
    parameter int unsigned GAP_CYCLES    = 4,
    parameter int unsigned FRM_CNT_WIDTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_en_i,
    input  logic                     cfg_vld_i,
    output logic                     cfg_rdy_o,
    input  logic                     cfg_pol_i,
    input  logic [1:0]               cfg_chm_i,
    input  logic [1:0]               cfg_chl_i,
    input  logic [DIV_WIDTH-1:0]     cfg_div_i,
    input  logic                     ws_i,
    output logic                     gen_en_o,
    output logic                     gen_pol_o,
    output logic [1:0]               gen_chm_o,
    output logic [1:0]               gen_chl_o,
    output logic [DIV_WIDTH-1:0]     gen_div_o,
    output logic                     busy_o,
    output logic                     frm_tick_o,
    output logic [FRM_CNT_WIDTH-1:0] frm_cnt_o,
    output logic                     tmo_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_GAP
    } state_t;

    localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);

    state_t                   state_q, state_d;
    logic                     ws_q;
    logic                     en_q, en_d;
    logic                     pol_q, pol_d;
    logic [1:0]               chm_q, chm_d;
    logic [1:0]               chl_q, chl_d;
    logic [DIV_WIDTH-1:0]     div_q, div_d;
    logic                     pend_q, pend_d;
    logic                     ppol_q, ppol_d;
    logic [1:0]               pchm_q, pchm_d;
    logic [1:0]               pchl_q, pchl_d;
    logic [DIV_WIDTH-1:0]     pdiv_q, pdiv_d;
    logic [7:0]               gap_q, gap_d;
    logic                     tick_q, tick_d;
    logic [FRM_CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic mono;
    logic ws_edge;
    logic fb;
    logic accept;
    logic wd_fire;

`ifdef I2S_CLKCTRL_TMO_EN
    logic [15:0] wd_q, wd_d;
    logic        tmo_q, tmo_d;

    assign wd_fire = (wd_q == '0);
    assign tmo_o   = tmo_q;
`else
    assign wd_fire = 1'b0;
    assign tmo_o   = 1'b0;
`endif

    // Mono modes have no useful WS edge, so DRAIN ends on its first cycle.
    assign mono    = (chm_q == 2'd1) || (chm_q == 2'd2);
    assign ws_edge = ((state_q == ST_RUN) || (state_q == ST_DRAIN)) &&
                     (ws_q == pol_q) && (ws_i == ~pol_q);
    assign fb      = mono ? (state_q == ST_DRAIN) : ws_edge;

    assign cfg_rdy_o = (state_q == ST_IDLE) || ((state_q == ST_RUN) && !pend_q);
    assign busy_o    = (state_q != ST_IDLE);
    assign accept    = cfg_vld_i && cfg_rdy_o;

    always_comb begin
        state_d = state_q;
        en_d    = en_q;
        pol_d   = pol_q;
        chm_d   = chm_q;
        chl_d   = chl_q;
        div_d   = div_q;
        pend_d  = pend_q;
        ppol_d  = ppol_q;
        pchm_d  = pchm_q;
        pchl_d  = pchl_q;
        pdiv_d  = pdiv_q;
        gap_d   = gap_q;
        tick_d  = !mono && ws_edge;
        cnt_d   = cnt_q + {{(FRM_CNT_WIDTH-1){1'b0}}, tick_d};
`ifdef I2S_CLKCTRL_TMO_EN
        wd_d    = wd_q;
        tmo_d   = tmo_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    pol_d = cfg_pol_i;
                    chm_d = cfg_chm_i;
                    chl_d = cfg_chl_i;
                    div_d = cfg_div_i;
                end
                if (req_en_i) begin
                    en_d    = 1'b1;
                    state_d = ST_RUN;
`ifdef I2S_CLKCTRL_TMO_EN
                    tmo_d   = 1'b0;
`endif
                end
            end
            ST_RUN: begin
                if (accept) begin
                    ppol_d  = cfg_pol_i;
                    pchm_d  = cfg_chm_i;
                    pchl_d  = cfg_chl_i;
                    pdiv_d  = cfg_div_i;
                    pend_d  = 1'b1;
                    state_d = ST_DRAIN;
                end else if (!req_en_i) begin
                    state_d = ST_DRAIN;
                end
`ifdef I2S_CLKCTRL_TMO_EN
                if (state_d == ST_DRAIN) wd_d = '1;
`endif
            end
            ST_DRAIN: begin
                if (fb || wd_fire) begin
                    en_d = 1'b0;
                    if (pend_q) begin
                        pol_d  = ppol_q;
                        chm_d  = pchm_q;
                        chl_d  = pchl_q;
                        div_d  = pdiv_q;
                        pend_d = 1'b0;
                    end
                    gap_d   = GAP_LOAD;
                    state_d = ST_GAP;
`ifdef I2S_CLKCTRL_TMO_EN
                    if (!fb) tmo_d = 1'b1;
                end else begin
                    wd_d = wd_q - 16'd1;
`endif
                end
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    if (req_en_i) begin
                        en_d    = 1'b1;
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            ws_q    <= 1'b0;
            en_q    <= 1'b0;
            pol_q   <= 1'b0;
            chm_q   <= '0;
            chl_q   <= '0;
            div_q   <= '0;
            pend_q  <= 1'b0;
            ppol_q  <= 1'b0;
            pchm_q  <= '0;
            pchl_q  <= '0;
            pdiv_q  <= '0;
            gap_q   <= '0;
            tick_q  <= 1'b0;
            cnt_q   <= '0;
`ifdef I2S_CLKCTRL_TMO_EN
            wd_q    <= '1;
            tmo_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ws_q    <= ws_i;
            en_q    <= en_d;
            pol_q   <= pol_d;
            chm_q   <= chm_d;
            chl_q   <= chl_d;
            div_q   <= div_d;
            pend_q  <= pend_d;
            ppol_q  <= ppol_d;
            pchm_q  <= pchm_d;
            pchl_q  <= pchl_d;
            pdiv_q  <= pdiv_d;
            gap_q   <= gap_d;
            tick_q  <= tick_d;
            cnt_q   <= cnt_d;
`ifdef I2S_CLKCTRL_TMO_EN
            wd_q    <= wd_d;
            tmo_q   <= tmo_d;
`endif
        end
    end

    assign gen_en_o   = en_q;
    assign gen_pol_o  = pol_q;
    assign gen_chm_o  = chm_q;
    assign gen_chl_o  = chl_q;
    assign gen_div_o  = div_q;
    assign frm_tick_o = tick_q;
    assign frm_cnt_o  = cnt_q;

endmodule

// File: tb/tb_i2s_clkctrl.sv
// Randomized bench for i2s_clkctrl against a cycle-level behavioural model of the sequencer rules.
module tb_i2s_clkctrl;
    localparam int DW  = 8;
    localparam int GAP = 4;
    localparam int CW  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_en, cfg_vld, cfg_rdy, cfg_pol, ws;
    logic [1:0]    cfg_chm, cfg_chl;
    logic [DW-1:0] cfg_div;
    logic          gen_en, gen_pol, busy, frm_tick, tmo;
    logic [1:0]    gen_chm, gen_chl;
    logic [DW-1:0] gen_div;
    logic [CW-1:0] frm_cnt;

    i2s_clkctrl #(.DIV_WIDTH(DW), .GAP_CYCLES(GAP), .FRM_CNT_WIDTH(CW)) dut (
        .clk_i(clk), .rst_i(rst), .req_en_i(req_en), .cfg_vld_i(cfg_vld), .cfg_rdy_o(cfg_rdy),
        .cfg_pol_i(cfg_pol), .cfg_chm_i(cfg_chm), .cfg_chl_i(cfg_chl), .cfg_div_i(cfg_div),
        .ws_i(ws), .gen_en_o(gen_en), .gen_pol_o(gen_pol), .gen_chm_o(gen_chm),
        .gen_chl_o(gen_chl), .gen_div_o(gen_div), .busy_o(busy), .frm_tick_o(frm_tick),
        .frm_cnt_o(frm_cnt), .tmo_o(tmo)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: phase 0 idle, 1 run, 2 drain, 3 gap
    int phase, m_chm, m_chl, m_div, p_chm, p_chl, p_div, gap_left, frames, wd;
    bit m_en, m_pol, pend, p_pol, last_ws, m_tick, m_tmo;

    task automatic model_reset();
        phase = 0; m_en = 0; m_pol = 0; m_chm = 0; m_chl = 0; m_div = 0;
        pend = 0; p_pol = 0; p_chm = 0; p_chl = 0; p_div = 0;
        gap_left = 0; frames = 0; last_ws = 0; m_tick = 0; m_tmo = 0; wd = 65535;
    endtask

    task automatic model_step();
        bit rdy, acc, mono, r2l, fb, wd_out;
        rdy    = (phase == 0) || (phase == 1 && !pend);
        acc    = cfg_vld && rdy;
        mono   = (m_chm == 1) || (m_chm == 2);
        r2l    = (phase == 1 || phase == 2) && (last_ws == m_pol) && (ws != m_pol);
        fb     = mono ? (phase == 2) : r2l;
        m_tick = !mono && r2l;
        if (m_tick) frames = (frames + 1) % (1 << CW);
        wd_out = 0;
`ifdef I2S_CLKCTRL_TMO_EN
        wd_out = (wd == 0);
`endif
        case (phase)
            0: begin
                if (acc) begin m_pol = cfg_pol; m_chm = cfg_chm; m_chl = cfg_chl; m_div = cfg_div; end
                if (req_en) begin phase = 1; m_en = 1; m_tmo = 0; end
            end
            1: begin
                if (acc) begin
                    p_pol = cfg_pol; p_chm = cfg_chm; p_chl = cfg_chl; p_div = cfg_div;
                    pend = 1; phase = 2; wd = 65535;
                end else if (!req_en) begin
                    phase = 2; wd = 65535;
                end
            end
            2: begin
                if (fb || wd_out) begin
                    if (!fb) m_tmo = 1;
                    m_en = 0;
                    if (pend) begin
                        m_pol = p_pol; m_chm = p_chm; m_chl = p_chl; m_div = p_div; pend = 0;
                    end
                    gap_left = GAP; phase = 3;
                end else begin
                    wd = wd - 1;
                end
            end
            default: begin
                gap_left = gap_left - 1;
                if (gap_left == 0) begin
                    if (req_en) begin phase = 1; m_en = 1; end
                    else phase = 0;
                end
            end
        endcase
        last_ws = ws;
    endtask

    task automatic compare_all();
        check("gen_en", gen_en, m_en);
        check("gen_pol", gen_pol, m_pol);
        check("gen_chm", gen_chm, m_chm);
        check("gen_chl", gen_chl, m_chl);
        check("gen_div", gen_div, m_div);
        check("busy", busy, phase != 0);
        check("cfg_rdy", cfg_rdy, (phase == 0) || (phase == 1 && !pend));
        check("frm_tick", frm_tick, m_tick);
        check("frm_cnt", frm_cnt, frames);
`ifdef I2S_CLKCTRL_TMO_EN
        check("tmo", tmo, m_tmo);
`else
        check("tmo", tmo, 0);
`endif
    endtask

    // Called at a negedge with inputs already set.
    task automatic step();
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    int ws_hold = 1;
    int ws_left = 1;
    task automatic ws_advance();
        ws_left--;
        if (ws_left <= 0) begin ws = ~ws; ws_left = ws_hold; end
    endtask

    task automatic set_cfg(input bit v, input bit p, input int m, input int l, input int d);
        cfg_vld = v; cfg_pol = p; cfg_chm = 2'(m); cfg_chl = 2'(l); cfg_div = DW'(d);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin ws_advance(); step(); end
    endtask

    task automatic async_reset();
        @(posedge clk);
        #2 rst = 1;
        model_reset();
        #1 compare_all();
        @(negedge clk);
        rst = 0; req_en = 0; ws = 0; set_cfg(0, 0, 0, 0, 0);
        compare_all();
    endtask

    initial begin
        rst = 1; req_en = 0; ws = 0; set_cfg(0, 0, 0, 0, 0);
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 0;
        compare_all();

        // IDLE: config and enable on the same edge
        set_cfg(1, 0, 0, 1, 3); req_en = 1;
        check("t1_rdy", cfg_rdy, 1);
        step();
        check("t1_div", gen_div, 3);
        check("t1_en", gen_en, 1);
        cfg_vld = 0;

        // Stereo reconfig mid-frame
        ws_hold = 8; ws_left = 8;
        run(20);
        set_cfg(1, 0, 0, 1, 7); ws_advance(); step(); cfg_vld = 0;
        run(60);
        check("t2_div", gen_div, 7);

        // Stop mid-frame
        run(5);
        req_en = 0;
        run(60);
        check("t3_busy", busy, 0);

        // Mono-left, WS constant
        ws = 0; ws_hold = 1000000; ws_left = ws_hold;
        set_cfg(1, 0, 1, 0, 2); req_en = 1; step(); cfg_vld = 0;
        run(5);
        set_cfg(1, 0, 1, 0, 5); step(); cfg_vld = 0;
        check("t4_busy", busy, 1);
        run(10);
        check("t4_cnt", frm_cnt, frames);

        // Async reset during DRAIN with pending, then during GAP
        set_cfg(1, 0, 0, 0, 9); step(); cfg_vld = 0;
        run(10);
        set_cfg(1, 1, 0, 2, 4); step(); cfg_vld = 0;
        run(3);
        async_reset();
        check("t6_div", gen_div, 0);
        set_cfg(1, 0, 1, 0, 6); req_en = 1; step(); cfg_vld = 0;
        run(3);
        req_en = 0; step(); step(); step();
        async_reset();

        // Frame counter wrap (counter narrowed via parameter)
        ws_hold = 1; ws_left = 1;
        set_cfg(1, 0, 0, 0, 1); req_en = 1; step(); cfg_vld = 0;
        run(2 * (1 << CW) + 10);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) req_en = ~req_en;
            if ($urandom_range(0, 7) == 0)
                set_cfg(1, 1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                        int'($urandom_range(0, 255)));
            else
                cfg_vld = 0;
            if (ws_left == 1) ws_hold = int'($urandom_range(1, 5));
            ws_advance();
            step();
        end

`ifdef I2S_CLKCTRL_TMO_EN
        async_reset();
        ws = 0; ws_hold = 1000000; ws_left = ws_hold;
        set_cfg(1, 0, 0, 0, 1); req_en = 1; step(); cfg_vld = 0;
        req_en = 0;
        run(65540);
        check("tmo_set", tmo, 1);
        check("tmo_en", gen_en, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
